// File: rtl/timer_controller_nfield.sv
// timer_controller_nfield: set/arm/run/pause/flash sequencer for NUM_FIELDS countdown fields
// Ports: clk, reset (async active-low); set, startStop (debounced levels, acted on at rising edge);
//   isTimeFlat (all fields zero), tick (countdown strobe); swEn (one-hot field being set),
//   fieldSet (sticky confirmed fields), decEn (RUN), flashEn (FLASH), paused (PAUSE), ready (READY).
// Define TIMER_CTRL_FLASH_TIMEOUT_EN to leave FLASH automatically after FLASH_TICKS ticks.
module timer_controller_nfield #(
  parameter int NUM_FIELDS  = 3,
  parameter int FLASH_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set,
  input  logic                  startStop,
  input  logic                  isTimeFlat,
  input  logic                  tick,
  output logic [NUM_FIELDS-1:0] swEn,
  output logic [NUM_FIELDS-1:0] fieldSet,
  output logic                  decEn,
  output logic                  flashEn,
  output logic                  paused,
  output logic                  ready
);
  localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  typedef enum logic [2:0] {S_SET, S_READY, S_RUN, S_PAUSE, S_FLASH} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_FIELDS-1:0] field_set_q, field_set_d, sw_en_q, sw_en_d;
  logic                  set_q, ss_q, dec_en_q, flash_en_q, paused_q, ready_q;
  logic                  set_edge, ss_edge, flash_done, restart;
  assign set_edge = set & ~set_q;
  assign ss_edge  = startStop & ~ss_q;
`ifdef TIMER_CTRL_FLASH_TIMEOUT_EN
  localparam int CW = $clog2(FLASH_TICKS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign flash_done = state_q == S_FLASH && tick && cnt_q == CW'(FLASH_TICKS - 1);
  // counts only while FLASH persists, so any exit leaves it cleared
  assign cnt_d = (state_q == S_FLASH && state_d == S_FLASH) ? cnt_q + CW'(tick) : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign flash_done  = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    field_set_d = field_set_q;
    restart     = 1'b0;
    case (state_q)
      S_SET:
        if (set_edge) begin
          field_set_d[idx_q] = 1'b1;
          if (idx_q == IW'(NUM_FIELDS - 1)) state_d = S_READY;
          else                              idx_d   = idx_q + 1'b1;
        end
      S_READY:
        if (set_edge)                      restart = 1'b1;
        else if (ss_edge && !isTimeFlat)   state_d = S_RUN;
      // reaching zero outranks any button in the same cycle
      S_RUN:
        if (isTimeFlat)   state_d = S_FLASH;
        else if (ss_edge) state_d = S_PAUSE;
      S_PAUSE:
        if (set_edge)     restart = 1'b1;
        else if (ss_edge) state_d = S_RUN;
      S_FLASH: restart = set_edge | ss_edge | flash_done;
      default: restart = 1'b1;
    endcase
    if (restart) begin
      state_d     = S_SET;
      idx_d       = '0;
      field_set_d = '0;
    end
    sw_en_d = state_d == S_SET ? NUM_FIELDS'(1) << idx_d : '0;
  end
  // outputs are decoded from the next state so they leave the flops together with it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= S_SET;
      idx_q       <= '0;
      field_set_q <= '0;
      set_q       <= 1'b0;
      ss_q        <= 1'b0;
      sw_en_q     <= NUM_FIELDS'(1);
      dec_en_q    <= 1'b0;
      flash_en_q  <= 1'b0;
      paused_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      field_set_q <= field_set_d;
      set_q       <= set;
      ss_q        <= startStop;
      sw_en_q     <= sw_en_d;
      dec_en_q    <= state_d == S_RUN;
      flash_en_q  <= state_d == S_FLASH;
      paused_q    <= state_d == S_PAUSE;
      ready_q     <= state_d == S_READY;
    end
  assign swEn     = sw_en_q;
  assign fieldSet = field_set_q;
  assign decEn    = dec_en_q;
  assign flashEn  = flash_en_q;
  assign paused   = paused_q;
  assign ready    = ready_q;
endmodule

// File: tb/tb_timer_controller_nfield.sv
// tb_timer_controller_nfield: randomized and directed checks of the sequencer against a behavioural model
module tb_timer_controller_nfield;
  localparam int NF = 3;
  localparam int FT = 4;
  localparam int M_SET = 0, M_READY = 1, M_RUN = 2, M_PAUSE = 3, M_FLASH = 4;
  logic clk = 0, rst_n = 0, set = 0, ss = 0, flat = 0, tick = 0;
  logic [NF-1:0] sw_en, field_set;
  logic dec_en, flash_en, paused, ready;
  int n_chk = 0, n_pass = 0;
  int m_mode, m_idx, m_fs, m_cnt;
  bit m_pset, m_pss;
  timer_controller_nfield #(.NUM_FIELDS(NF), .FLASH_TICKS(FT)) dut (
    .clk(clk), .reset(rst_n), .set(set), .startStop(ss), .isTimeFlat(flat), .tick(tick),
    .swEn(sw_en), .fieldSet(field_set), .decEn(dec_en), .flashEn(flash_en),
    .paused(paused), .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic m_reset();
    m_mode = M_SET; m_idx = 0; m_fs = 0; m_cnt = 0; m_pset = 0; m_pss = 0;
  endtask
  task automatic m_restart();
    m_mode = M_SET; m_idx = 0; m_fs = 0; m_cnt = 0;
  endtask
  task automatic m_step();
    bit se, sse;
    se = set && !m_pset;
    sse = ss && !m_pss;
    m_pset = set;
    m_pss = ss;
    case (m_mode)
      M_SET: if (se) begin
        m_fs |= 1 << m_idx;
        if (m_idx == NF - 1) m_mode = M_READY; else m_idx++;
      end
      M_READY: if (se) m_restart(); else if (sse && !flat) m_mode = M_RUN;
      M_RUN: if (flat) m_mode = M_FLASH; else if (sse) m_mode = M_PAUSE;
      M_PAUSE: if (se) m_restart(); else if (sse) m_mode = M_RUN;
      default: begin
`ifdef TIMER_CTRL_FLASH_TIMEOUT_EN
        if (tick) m_cnt++;
        if (se || sse || m_cnt == FT) m_restart();
`else
        if (se || sse) m_restart();
`endif
      end
    endcase
  endtask
  task automatic check_all(input string ph);
    check({ph, ".swEn"}, 32'(sw_en), m_mode == M_SET ? 1 << m_idx : 0);
    check({ph, ".fieldSet"}, 32'(field_set), m_fs);
    check({ph, ".decEn"}, 32'(dec_en), 32'(m_mode == M_RUN));
    check({ph, ".flashEn"}, 32'(flash_en), 32'(m_mode == M_FLASH));
    check({ph, ".paused"}, 32'(paused), 32'(m_mode == M_PAUSE));
    check({ph, ".ready"}, 32'(ready), 32'(m_mode == M_READY));
  endtask
  task automatic cyc(input string ph, input bit s, input bit p, input bit f, input bit t);
    @(negedge clk);
    set = s; ss = p; flat = f; tick = t;
    @(posedge clk);
    m_step();
    #1 check_all(ph);
  endtask
  task automatic press(input string ph, input bit s, input bit p, input bit f);
    cyc(ph, s, p, f, 0);
    cyc(ph, 0, 0, f, 0);
  endtask
  task automatic async_reset(input string ph);
    @(posedge clk);
    #3 rst_n = 0;
    set = 0; ss = 0; flat = 0; tick = 0;
    m_reset();
    #1 check_all(ph);
    @(negedge clk);
    @(negedge clk) rst_n = 1;
  endtask
  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1 check_all("rst_hold");
    rst_n = 1;
    cyc("rst_rel", 0, 0, 0, 0);
    check("rst_swEn_const", 32'(sw_en), 1);
    press("ss_in_set", 0, 1, 0);
    for (int i = 0; i < NF; i++) press("set_fields", 1, 0, 0);
    check("ready_const", 32'(ready), 1);
    check("fieldset_const", 32'(field_set), 7);
    press("ready_flat_ss", 0, 1, 1);
    press("to_run", 0, 1, 0);
    press("to_pause", 0, 1, 0);
    check("paused_const", 32'(paused), 1);
    press("resume", 0, 1, 0);
    press("flat_vs_ss", 0, 1, 1);
    check("flash_const", 32'(flash_en), 1);
    for (int i = 0; i < 20; i++) cyc("flash_ticks", 0, 0, 0, 1);
`ifdef TIMER_CTRL_FLASH_TIMEOUT_EN
    check("flash_timeout_const", 32'(flash_en), 0);
`else
    check("flash_hold_const", 32'(flash_en), 1);
    press("flash_set", 1, 0, 0);
`endif
    for (int i = 0; i < NF; i++) press("set_fields2", 1, 0, 0);
    press("both_edges", 1, 1, 0);
    check("both_swEn_const", 32'(sw_en), 1);
    for (int i = 0; i < NF; i++) press("set_fields3", 1, 0, 0);
    press("to_run2", 0, 1, 0);
    async_reset("async_rst");
    check("async_decEn_const", 32'(dec_en), 0);
    cyc("after_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
      else cyc("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
